fx_seq_src: RTL
===============

# fx_seq_src

Sample-sequencing source for the adaptive filter's input side. It replays an 8-entry reference-input table `x` and a 9-entry desired-signal table `d` into the filter, one pair per sample tick. On the same tick it captures the filter's error output `e` into a small FIFO drained over a valid/ready stream. It replaces bench-side stimulus and error logging so full adapt runs can execute in hardware.

## Interface
Parameters:
- `NFRAMES`, 50: number of 8-sample `x` frames per run.
- `EDEPTH`, 8: error FIFO depth; must be a power of two, at least 2.

Ports:
- `clk` in 1: the single clock; all logic is on its rising edge.
- `r` in 1: asynchronous reset, active-high.
- `start` in 1: one-cycle pulse; begins a run from IDLE or DONE.
- `tick` in 1: one-cycle sample strobe, already synchronous to `clk`.
- `wr_en` in 1: table write strobe. Present only with `FXSEQ_PROG_EN`.
- `wr_sel` in 1: table select, 0 = `x`, 1 = `d`. Present only with `FXSEQ_PROG_EN`.
- `wr_addr` in 4: table address. Present only with `FXSEQ_PROG_EN`.
- `wr_data` in 10: write data; only `[7:0]` is used for `x`. Present only with `FXSEQ_PROG_EN`.
- `x` out 8: reference sample driven to the filter.
- `d` out 10: desired sample driven to the filter.
- `e_in` in 10: filter error output.
- `busy` out 1: high in RUN and DRAIN.
- `done` out 1: high in DONE.
- `e_out` out 10: head entry of the error FIFO.
- `e_valid` out 1: FIFO not empty.
- `e_ready` in 1: consumer accepts `e_out` when `e_valid && e_ready`.
- `ovf` out 1: sticky error-FIFO overflow.

## Operation
- States and transitions:
  - IDLE: `start` → RUN.
  - RUN: the `8*NFRAMES`-th accepted tick → DRAIN.
  - DRAIN: FIFO empty → DONE.
  - DONE: `start` → RUN.
  - `start` in RUN or DRAIN is ignored.
- On RUN entry: indices `i`=0, `j`=0, frame counter `k`=0, FIFO flushed, `ovf` cleared.
- Each `tick` in RUN:
  - `x` ← `xt[i]`, `d` ← `dt[j]`.
  - `e_in` is pushed to the FIFO.
  - `i` ← (`i`+1) mod 8; `k` increments when `i` wraps from 7 to 0.
  - `j` ← 1 if `j`=8, else `j`+1. Index 0 of `d` is therefore used only on the first tick of a run.
- Ticks outside RUN are ignored.
- `x` and `d` hold their last values through DRAIN and DONE.
- FIFO boundary rules:
  - Push into a full FIFO with no pop in the same cycle: the sample is dropped and `ovf` is set.
  - Push and pop in the same cycle when full: both succeed.
  - Pop when empty: no effect.
- Table reset contents:
  - `xt` = 16, 32, 48, 32, 16, 0, 0, 0.
  - `dt` = 0, 8, 20, 34, 33, 24, 11, 4, 1.
- Reset, including mid-run: state IDLE; `x`, `d`, `e_out`, `busy`, `done`, `e_valid`, `ovf` all 0; FIFO empty; tables return to reset contents.

## Timing
- `x` and `d` are registered; they change in the cycle after the accepted `tick`.
- `e_in` is sampled in the `tick` cycle itself. The pushed error therefore belongs to the previous `x`/`d` pair; the first push of a run is the post-reset or previous-run error.
- FIFO latency: a push in cycle n gives `e_valid` in cycle n+1; `e_out` is registered or from memory, valid while `e_valid`.
- `busy` rises the cycle after `start`. `done` rises the cycle after the FIFO empties in DRAIN.
- `tick` and `start` in the same IDLE cycle: the tick is ignored.

## Configuration
- `FXSEQ_PROG_EN` defined:
  - Tables are writable through `wr_*`, only in IDLE or DONE.
  - Writes in RUN or DRAIN are ignored.
  - Out-of-range addresses (`x` > 7, `d` > 8) are ignored.
- `FXSEQ_PROG_EN` undefined: the `wr_*` ports are absent and the tables are constant ROMs holding the reset contents.

## Structure
- Shared package `fx_pkg` holds:
  - widths `XW`=8 and `DW`=10;
  - table lengths 8 and 9;
  - the default table constants;
  - the state enum.
- One sub-module, `fx_efifo`: synchronous FIFO of `EDEPTH` × 10 bits with full/empty flags and push/pop. It is instantiated once.

## Test plan
- Default tables, `NFRAMES`=2, `tick` every 6 cycles, `e_ready`=1 → `x` sequence 16,32,48,32,16,0,0,0 repeated twice; `d` sequence 0,8,20,34,33,24,11,4,1,8,20,…; exactly 16 FIFO pushes; `done` after drain.
- `e_in` = tick index, `e_ready`=0, `EDEPTH`=8, 10 ticks → 8 entries held, `ovf`=1; then `e_ready`=1 → pops 0..7 in order.
- FIFO full with `tick` and `e_ready` in the same cycle → no drop, `ovf` stays 0, occupancy stays 8.
- Reset asserted mid-RUN at `i`=3 → next cycle all outputs are 0 and state is IDLE; a following `start` restarts at `x`=16, `d`=0.
- `FXSEQ_PROG_EN`: write `xt[0]`=5 and `dt[0]`=7 in IDLE, run → first `x`=5, `d`=7. A write during RUN to `xt[1]` is not reflected in the output.
- `start` pulsed during RUN → ignored; the run length is still `8*NFRAMES` ticks.

Source files
------------

// File: rtl/fx_pkg.sv
// rtl/fx_pkg.sv - shared widths, table lengths, default table contents and state encoding
package fx_pkg;

  localparam int XW   = 8;
  localparam int DW   = 10;
  localparam int XLEN = 8;
  localparam int DLEN = 9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  function automatic logic [XW-1:0] xt_default(input logic [2:0] idx);
    case (idx)
      3'd0:    return 8'd16;
      3'd1:    return 8'd32;
      3'd2:    return 8'd48;
      3'd3:    return 8'd32;
      3'd4:    return 8'd16;
      default: return 8'd0;
    endcase
  endfunction

  function automatic logic [DW-1:0] dt_default(input logic [3:0] idx);
    case (idx)
      4'd1:    return 10'd8;
      4'd2:    return 10'd20;
      4'd3:    return 10'd34;
      4'd4:    return 10'd33;
      4'd5:    return 10'd24;
      4'd6:    return 10'd11;
      4'd7:    return 10'd4;
      4'd8:    return 10'd1;
      default: return 10'd0;
    endcase
  endfunction

endpackage

// File: rtl/fx_efifo.sv
// rtl/fx_efifo.sv - synchronous error FIFO, DEPTH x W, head entry read straight from memory
module fx_efifo #(
  parameter int DEPTH = 8,
  parameter int W     = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;

  assign empty    = (r_cnt == '0);
  assign full     = (r_cnt == CNT_FULL);
  assign w_pop    = pop && !empty;
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign w_push   = push && (!full || w_pop);
  assign pop_data = empty ? '0 : r_mem[r_rp];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      if (w_push && !w_pop)      r_cnt <= r_cnt + (AW+1)'(1);
      else if (w_pop && !w_push) r_cnt <= r_cnt - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= push_data;
  end

endmodule

// File: rtl/fx_seq_src.sv
// rtl/fx_seq_src.sv - replays x/d tables per tick and captures e_in into a stream FIFO
// FXSEQ_PROG_EN adds the wr_* ports and makes the tables writable in IDLE/DONE.
module fx_seq_src
  import fx_pkg::*;
#(
  parameter int NFRAMES = 50,
  parameter int EDEPTH  = 8
) (
  input  logic          clk,
  input  logic          r,
  input  logic          start,
  input  logic          tick,
`ifdef FXSEQ_PROG_EN
  input  logic          wr_en,
  input  logic          wr_sel,
  input  logic [3:0]    wr_addr,
  input  logic [DW-1:0] wr_data,
`endif
  output logic [XW-1:0] x,
  output logic [DW-1:0] d,
  input  logic [DW-1:0] e_in,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] e_out,
  output logic          e_valid,
  input  logic          e_ready,
  output logic          ovf
);

  localparam int KW = (NFRAMES > 1) ? $clog2(NFRAMES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NFRAMES - 1);

  state_t        r_state;
  logic [2:0]    r_i;
  logic [3:0]    r_j;
  logic [KW-1:0] r_k;
  logic [XW-1:0] r_x;
  logic [DW-1:0] r_d;
  logic          r_busy;
  logic          r_done;
  logic          r_ovf;

  logic          w_idle_or_done;
  logic          w_start_run;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic          w_last_tick;
  logic [XW-1:0] w_xv;
  logic [DW-1:0] w_dv;

  assign w_idle_or_done = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_start_run    = start && w_idle_or_done;
  assign w_push         = tick && (r_state == ST_RUN);
  assign w_pop          = e_valid && e_ready;
  assign w_last_tick    = w_push && (r_i == 3'd7) && (r_k == K_LAST);

`ifdef FXSEQ_PROG_EN
  logic [XW-1:0] r_xt [XLEN];
  logic [DW-1:0] r_dt [DLEN];

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      for (int n = 0; n < XLEN; n++) r_xt[n] <= xt_default(3'(n));
      for (int n = 0; n < DLEN; n++) r_dt[n] <= dt_default(4'(n));
    end else if (wr_en && w_idle_or_done) begin
      if (!wr_sel && (wr_addr < 4'd8))     r_xt[wr_addr[2:0]] <= wr_data[XW-1:0];
      else if (wr_sel && (wr_addr < 4'd9)) r_dt[wr_addr]      <= wr_data;
    end
  end

  assign w_xv = r_xt[r_i];
  assign w_dv = r_dt[r_j];
`else
  assign w_xv = xt_default(r_i);
  assign w_dv = dt_default(r_j);
`endif

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      r_state <= ST_IDLE;
      r_i     <= '0;
      r_j     <= '0;
      r_k     <= '0;
      r_x     <= '0;
      r_d     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_start_run) begin
            r_state <= ST_RUN;
            r_i     <= '0;
            r_j     <= '0;
            r_k     <= '0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (w_push) begin
            r_x <= w_xv;
            r_d <= w_dv;
            r_i <= r_i + 3'd1;
            // d index 0 is only the run's first sample; afterwards it cycles 1..8
            r_j <= (r_j == 4'd8) ? 4'd1 : r_j + 4'd1;
            if (r_i == 3'd7) r_k <= r_k + KW'(1);
            if (w_full && !w_pop) r_ovf <= 1'b1;
            if (w_last_tick) r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_empty) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  fx_efifo #(
    .DEPTH(EDEPTH),
    .W    (DW)
  ) u_efifo (
    .clk      (clk),
    .rst      (r),
    .flush    (w_start_run),
    .push     (w_push),
    .push_data(e_in),
    .pop      (e_ready),
    .pop_data (e_out),
    .full     (w_full),
    .empty    (w_empty)
  );

  assign e_valid = !w_empty;
  assign x       = r_x;
  assign d       = r_d;
  assign busy    = r_busy;
  assign done    = r_done;
  assign ovf     = r_ovf;

endmodule
